// File: rtl/hub75_panel_receiver.sv
// HUB75 panel receiver: synchronizes the panel-side HUB75 signals into the
// system clock domain, shifts pixel columns on SCLK, and commits the row pair
// into a 32x32 RGB frame store on LAT. It also provides readback, row/frame
// event pulses, a sticky row-length error and an OE on-time measurement.
module hub75_panel_receiver #(
   parameter int COLS        = 32,
   parameter int ROWS_HALF   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        SCLK,
   input  logic        LAT,
   input  logic        OE,
   input  logic        A,
   input  logic        B,
   input  logic        C,
   input  logic        D,
   input  logic        R0,
   input  logic        G0,
   input  logic        B0,
   input  logic        R1,
   input  logic        G1,
   input  logic        B1,
   input  logic [4:0]  rd_row,
   input  logic [4:0]  rd_col,
   output logic [2:0]  rd_rgb,
   output logic        row_valid,
   output logic [3:0]  last_row,
   output logic        frame_done,
   output logic [15:0] frame_count,
   output logic        len_err,
   output logic [15:0] oe_on_cycles
);

   localparam int         NIN       = 13;
   localparam logic [5:0] COLS_FULL = 6'(COLS);
   localparam logic [5:0] COLS_SAT  = 6'(COLS + 1);

   // Bundle every panel input so the synchronizer treats them identically.
   logic [NIN-1:0] pinVec;
   assign pinVec = {SCLK, LAT, OE, D, C, B, A, R0, G0, B0, R1, G1, B1};

   logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
   logic                            sclkDly_q;
   logic                            latDly_q;

   logic [NIN-1:0] synced;
   logic           sclkS;
   logic           latS;
   logic           oeS;
   logic [3:0]     rowS;
   logic [5:0]     pixS;
   logic           sclkRise;
   logic           latRise;

   assign synced   = sync_q[SYNC_STAGES-1];
   assign sclkS    = synced[12];
   assign latS     = synced[11];
   assign oeS      = synced[10];
   assign rowS     = synced[9:6];
   assign pixS     = synced[5:0];
   assign sclkRise = sclkS & ~sclkDly_q;
   assign latRise  = latS & ~latDly_q;

   // Synchronizer chain plus the delayed copies used for SCLK/LAT edge detect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q    <= '0;
         sclkDly_q <= 1'b0;
         latDly_q  <= 1'b0;
      end else begin
         sync_q[0] <= pinVec;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         sclkDly_q <= sclkS;
         latDly_q  <= latS;
      end
   end

   logic [COLS-1:0][5:0] shift_q, shift_d;
   logic [5:0]           colCnt_q, colCnt_d, colShift;
   logic [15:0]          oeAcc_q, oeAcc_d, oeInc;
   logic [15:0]          oeOn_q, oeOn_d;
   logic                 lenErr_q, lenErr_d;
   logic [3:0]           lastRow_q, lastRow_d;
   logic                 rowValid_q, rowValid_d;
   logic                 frameDone_q, frameDone_d;
   logic [15:0]          frameCnt_q, frameCnt_d;

   // Next-state for shifting, commit bookkeeping, frame tracking and OE timing.
   // The shift is resolved before the commit so a coincident SCLK/LAT commits
   // the freshly shifted pixel and the incremented count. last_row doubles as
   // the previous-commit row used for frame detection.
   always_comb begin
      shift_d  = shift_q;
      colShift = colCnt_q;
      if (sclkRise) begin
         shift_d[0] = pixS;
         for (int i = 1; i < COLS; i++) begin
            shift_d[i] = shift_q[i-1];
         end
         if (colCnt_q != COLS_SAT) begin
            colShift = colCnt_q + 6'd1;
         end
      end
      colCnt_d    = latRise ? 6'd0 : colShift;
      oeInc       = (!oeS && oeAcc_q != 16'hFFFF) ? oeAcc_q + 16'd1 : oeAcc_q;
      oeAcc_d     = latRise ? 16'd0 : oeInc;
      oeOn_d      = latRise ? oeInc : oeOn_q;
      lenErr_d    = lenErr_q | (latRise && colShift != COLS_FULL);
      lastRow_d   = latRise ? rowS : lastRow_q;
      rowValid_d  = latRise;
      frameDone_d = latRise && rowS == 4'd15 && lastRow_q == 4'd14;
      frameCnt_d  = frameDone_d ? frameCnt_q + 16'd1 : frameCnt_q;
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q     <= '0;
         colCnt_q    <= '0;
         oeAcc_q     <= '0;
         oeOn_q      <= '0;
         lenErr_q    <= 1'b0;
         lastRow_q   <= '0;
         rowValid_q  <= 1'b0;
         frameDone_q <= 1'b0;
         frameCnt_q  <= '0;
      end else begin
         shift_q     <= shift_d;
         colCnt_q    <= colCnt_d;
         oeAcc_q     <= oeAcc_d;
         oeOn_q      <= oeOn_d;
         lenErr_q    <= lenErr_d;
         lastRow_q   <= lastRow_d;
         rowValid_q  <= rowValid_d;
         frameDone_q <= frameDone_d;
         frameCnt_q  <= frameCnt_d;
      end
   end

   logic [2*ROWS_HALF-1:0][COLS-1:0][2:0] frame_q;

   // Frame store: a commit writes the upper-half pixel into row A-D and the
   // lower-half pixel into the matching row 16 lines below.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_q <= '0;
      end else if (latRise) begin
         for (int c = 0; c < COLS; c++) begin
            frame_q[{1'b0, rowS}][c] <= shift_d[c][5:3];
            frame_q[{1'b1, rowS}][c] <= shift_d[c][2:0];
         end
      end
   end

   logic [2:0] rdRgb_q;

   // Registered readback; a same-cycle commit shows up one cycle later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdRgb_q <= '0;
      end else begin
         rdRgb_q <= frame_q[rd_row][rd_col];
      end
   end

   assign rd_rgb       = rdRgb_q;
   assign row_valid    = rowValid_q;
   assign last_row     = lastRow_q;
   assign frame_done   = frameDone_q;
   assign frame_count  = frameCnt_q;
   assign len_err      = lenErr_q;
   assign oe_on_cycles = oeOn_q;

endmodule
